uart_rx_buffered: RTL and testbench

Parametrised UART receiver with configurable frame format, per-frame error flags and an on-chip receive FIFO. It oversamples the asynchronous serial line at the system clock, recovers frames of 5–9 data bits with optional parity and 1 or 2 stop bits, and pushes each frame with its error flags into a show-ahead FIFO. A valid/ready handshake drains the FIFO. It replaces the single-word receiver where software or DMA cannot service every frame within one frame time.

---
 rtl/uart_rx_buffered_if.sv | 20 ++
 rtl/uart_rx_buffered.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_buffered.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_buffered_if.sv
// uart_rx_buffered_if: receive FIFO head, drained by valid/ready.
`timescale 1ns/1ps
interface uart_rx_buffered_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] data;
  logic                  parity_err;
  logic                  frame_err;
  logic                  valid;
  logic                  ready;

  modport master (
    output data, parity_err, frame_err, valid,
    input  ready
  );
  modport slave (
    input  data, parity_err, frame_err, valid,
    output ready
  );
endinterface

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: oversampling UART receiver feeding a show-ahead FIFO
// of {frame_err, parity_err, data} entries.
`timescale 1ns/1ps
module uart_rx_buffered #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 19200,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx,
  uart_rx_buffered_if.master    rxo,
  output logic [CW-1:0]         count,
  output logic                  overrun,
  input  logic                  clr_overrun
);

  localparam int PW   = CLK_FREQ / BAUD_RATE;
  localparam int HALF = PW / 2;
  localparam int TW   = $clog2(PW + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int EW   = DATA_WIDTH + 2;
  localparam logic ODD = (PARITY == 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_e;

  logic [1:0]            sync_q, sync_d;
  logic                  rxs;
  state_e                state_q, state_d;
  logic                  armed_q, armed_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [3:0]            bitn_q, bitn_d;
  logic [DATA_WIDTH-1:0] shf_q, shf_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  push;
  logic                  tick;
  logic [EW-1:0]         pword;

  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [EW-1:0]         mem_d [FIFO_DEPTH];
  logic [AW-1:0]         wp_q, wp_d;
  logic [AW-1:0]         rp_q, rp_d;
  logic [CW-1:0]         fcnt_q, fcnt_d;
  logic                  ovr_q, ovr_d;
  logic                  full, pop, wr;

  assign sync_d = {sync_q[0], rx};
  assign rxs    = sync_q[1];
  assign tick   = (tmr_q == '0);

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    tmr_d   = tmr_q;
    bitn_d  = bitn_q;
    shf_d   = shf_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push    = 1'b0;
    pword   = {ferr_q | ~rxs, perr_q, shf_q};
    if (state_q != IDLE && !tick) tmr_d = tmr_q - 1'b1;
    unique case (state_q)
      IDLE: begin
        if (rxs) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          tmr_d   = TW'(HALF - 1);
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (rxs) begin
            armed_d = 1'b1;
            state_d = IDLE;
          end else begin
            tmr_d   = TW'(PW - 1);
            bitn_d  = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shf_d  = {rxs, shf_q[DATA_WIDTH-1:1]};
          tmr_d  = TW'(PW - 1);
          bitn_d = bitn_q + 1'b1;
          if (bitn_q == 4'(DATA_WIDTH - 1)) begin
            bitn_d  = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end
        end
      end
      PAR: begin
        if (tick) begin
          perr_d  = ((^shf_q) ^ rxs) != ODD;
          tmr_d   = TW'(PW - 1);
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          ferr_d = ferr_q | ~rxs;
          tmr_d  = TW'(PW - 1);
          bitn_d = bitn_q + 1'b1;
          // Re-arming waits for a high line so a break yields one frame
          if (bitn_q == 4'(STOP_BITS - 1)) begin
            push    = 1'b1;
            armed_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full = (fcnt_q == CW'(FIFO_DEPTH));
  assign pop  = (fcnt_q != '0) && rxo.ready;
  assign wr   = push && (!full || pop);

  always_comb begin
    mem_d  = mem_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    fcnt_d = fcnt_q;
    ovr_d  = ovr_q;
    if (wr) begin
      mem_d[wp_q] = pword;
      wp_d        = wp_q + 1'b1;
    end
    if (pop) rp_d = rp_q + 1'b1;
    if (wr && !pop) fcnt_d = fcnt_q + CW'(1);
    else if (!wr && pop) fcnt_d = fcnt_q - CW'(1);
    if (push && full && !pop) ovr_d = 1'b1;
    else if (clr_overrun) ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      armed_q <= 1'b0;
      tmr_q   <= '0;
      bitn_q  <= '0;
      shf_q   <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      fcnt_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      armed_q <= armed_d;
      tmr_q   <= tmr_d;
      bitn_q  <= bitn_d;
      shf_q   <= shf_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      fcnt_q  <= fcnt_d;
      ovr_q   <= ovr_d;
    end
  end

  // Head is read straight from storage: it only moves on pop or fill-from-empty
  assign rxo.data       = mem_q[rp_q][DATA_WIDTH-1:0];
  assign rxo.parity_err = mem_q[rp_q][DATA_WIDTH];
  assign rxo.frame_err  = mem_q[rp_q][DATA_WIDTH+1];
  assign rxo.valid      = (fcnt_q != '0);
  assign count          = fcnt_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: three receivers (even, odd, none+2 stop) on one
// line; expected entries queued at send time, checked at pop time.
`timescale 1ns/1ps
module tb_uart_rx_buffered;

  localparam int PW = 8;
  localparam int CW = 5;

  logic clk, rstn, rx, ready, clr;
  logic [CW-1:0] cnt_e, cnt_o, cnt_n;
  logic ovr_e, ovr_o, ovr_n;
  int n_vec = 0;
  int n_bad = 0;
  logic [9:0] qe[$], qo[$], qn[$];

  uart_rx_buffered_if #(.DATA_WIDTH(8)) ife ();
  uart_rx_buffered_if #(.DATA_WIDTH(8)) ifo ();
  uart_rx_buffered_if #(.DATA_WIDTH(8)) ifn ();
  assign ife.ready = ready;
  assign ifo.ready = ready;
  assign ifn.ready = ready;

  uart_rx_buffered #(
    .DATA_WIDTH(8), .BAUD_RATE(100_000), .CLK_FREQ(800_000),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) dut_e (
    .clk(clk), .rstn(rstn), .rx(rx), .rxo(ife),
    .count(cnt_e), .overrun(ovr_e), .clr_overrun(clr)
  );
  uart_rx_buffered #(
    .DATA_WIDTH(8), .BAUD_RATE(100_000), .CLK_FREQ(800_000),
    .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) dut_o (
    .clk(clk), .rstn(rstn), .rx(rx), .rxo(ifo),
    .count(cnt_o), .overrun(ovr_o), .clr_overrun(clr)
  );
  uart_rx_buffered #(
    .DATA_WIDTH(8), .BAUD_RATE(100_000), .CLK_FREQ(800_000),
    .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)
  ) dut_n (
    .clk(clk), .rstn(rstn), .rx(rx), .rxo(ifn),
    .count(cnt_n), .overrun(ovr_n), .clr_overrun(clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && ife.valid && ready) begin
      if (qe.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL pop_e got %0h want none", ife.data);
      end else begin
        chk("pop_e", 32'({ife.frame_err, ife.parity_err, ife.data}),
            32'(qe.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && ifo.valid && ready) begin
      if (qo.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL pop_o got %0h want none", ifo.data);
      end else begin
        chk("pop_o", 32'({ifo.frame_err, ifo.parity_err, ifo.data}),
            32'(qo.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && ifn.valid && ready) begin
      if (qn.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL pop_n got %0h want none", ifn.data);
      end else begin
        chk("pop_n", 32'({ifn.frame_err, ifn.parity_err, ifn.data}),
            32'(qn.pop_front()));
      end
    end
  end

  // even: flag when data^pbit odd; odd: the inverse; none+2stop: pbit is stop 1
  task automatic push_exp(input logic [7:0] d, input logic pb,
                          input logic sb);
    logic x;
    x = (^d) ^ pb;
    qe.push_back({~sb, x, d});
    qo.push_back({~sb, ~x, d});
    qn.push_back({~(pb & sb), 1'b0, d});
  endtask

  task automatic bitx(input logic v);
    rx = v;
    repeat (PW) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic pb,
                      input logic sb, input bit exp, input int idle);
    if (exp) push_exp(d, pb, sb);
    bitx(1'b0);
    for (int i = 0; i < 8; i++) bitx(d[i]);
    bitx(pb);
    bitx(sb);
    for (int i = 0; i < idle; i++) bitx(1'b1);
  endtask

  task automatic drain();
    ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (qe.size() == 0 && qo.size() == 0 && qn.size() == 0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("left_e", 32'(qe.size()), 0);
    chk("left_o", 32'(qo.size()), 0);
    chk("left_n", 32'(qn.size()), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_e"}, 32'({ife.valid, ife.frame_err, ife.parity_err,
        ife.data, cnt_e, ovr_e}), 0);
    chk({tag, "_o"}, 32'({ifo.valid, ifo.frame_err, ifo.parity_err,
        ifo.data, cnt_o, ovr_o}), 0);
    chk({tag, "_n"}, 32'({ifn.valid, ifn.frame_err, ifn.parity_err,
        ifn.data, cnt_n, ovr_n}), 0);
  endtask

  task automatic chk_cnt(input string tag, input int c, input logic o);
    chk({tag, "_cnt_e"}, 32'(cnt_e), 32'(c));
    chk({tag, "_cnt_o"}, 32'(cnt_o), 32'(c));
    chk({tag, "_cnt_n"}, 32'(cnt_n), 32'(c));
    chk({tag, "_ovr_e"}, 32'(ovr_e), 32'(o));
    chk({tag, "_ovr_o"}, 32'(ovr_o), 32'(o));
    chk({tag, "_ovr_n"}, 32'(ovr_n), 32'(o));
  endtask

  initial begin
    rx = 1'b1; ready = 1'b0; clr = 1'b0; rstn = 1'b0;
    #12;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    bitx(1'b1);
    bitx(1'b1);

    ready = 1'b1;
    for (int d = 0; d < 256; d++)
      send(8'(d), ^(8'(d)), 1'b1, 1'b1, 0);
    drain();
    chk_cnt("sweep", 0, 1'b0);

    send(8'hA5, 1'b0, 1'b1, 1'b1, 1);
    send(8'hA5, 1'b1, 1'b1, 1'b1, 1);
    send(8'h3C, 1'b0, 1'b0, 1'b1, 2);
    send(8'h55, 1'b0, 1'b1, 1'b1, 1);
    drain();

    push_exp(8'h00, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (3 * 11 * PW) @(posedge clk);
    #1;
    rx = 1'b1;
    for (int i = 0; i < 22; i++) bitx(1'b1);
    drain();
    chk_cnt("break", 0, 1'b0);

    ready = 1'b0;
    for (int i = 1; i <= 17; i++)
      send(8'(i), ^(8'(i)), 1'b1, i <= 16, 0);
    bitx(1'b1);
    chk_cnt("full", 16, 1'b1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk_cnt("clr", 16, 1'b0);

    // pop lands on the edge that closes the last stop-sample cycle
    fork
      send(8'h22, 1'b0, 1'b1, 1'b1, 0);
      begin
        repeat (86) @(posedge clk);
        #1;
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
      end
    join
    bitx(1'b1);
    chk_cnt("fullpop", 16, 1'b0);
    drain();

    rx = 1'b0;
    repeat (PW / 4) @(posedge clk);
    #1;
    rx = 1'b1;
    for (int i = 0; i < 12; i++) bitx(1'b1);
    chk_cnt("glitch", 0, 1'b0);

    ready = 1'b0;
    send(8'h5A, 1'b0, 1'b1, 1'b1, 1);
    chk_cnt("prerst", 1, 1'b0);
    bitx(1'b0);
    bitx(1'b1);
    bitx(1'b0);
    bitx(1'b0);
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk_zero("async_rst");
    qe.delete(); qo.delete(); qn.delete();
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rstn = 1'b1;
    bitx(1'b1);
    ready = 1'b1;
    send(8'h81, 1'b0, 1'b1, 1'b1, 2);
    drain();
    chk_cnt("final", 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
